// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter.
package morse_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StCharGap
    } morse_state_e;

    // Character code map: letters first, then digits
    localparam int unsigned CODE_A   = 0;
    localparam int unsigned CODE_0   = 26;
    localparam int unsigned CODE_MAX = 35;

    // Longest ITU character (digits) has five symbols
    localparam int unsigned MORSE_MAX_LEN = 5;

    // Width of the widest ROM pattern
    localparam int unsigned ROM_PAT_W = 5;

    // Largest of three unit counts, used to size the unit counter
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ITU Morse lookup: char code -> valid, symbol count, MSB-first pattern (1 = dash).
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] char_code,
    output logic       valid,
    output logic [2:0] length,
    output logic [4:0] pattern
);

    logic [7:0] entry;

    // Table lookup; entry = {length, pattern}, pattern left-aligned
    always_comb begin
        entry = 8'h00;
        unique case (char_code)
            6'd0:  entry = {3'd2, 5'b01000}; // A .-
            6'd1:  entry = {3'd4, 5'b10000}; // B -...
            6'd2:  entry = {3'd4, 5'b10100}; // C -.-.
            6'd3:  entry = {3'd3, 5'b10000}; // D -..
            6'd4:  entry = {3'd1, 5'b00000}; // E .
            6'd5:  entry = {3'd4, 5'b00100}; // F ..-.
            6'd6:  entry = {3'd3, 5'b11000}; // G --.
            6'd7:  entry = {3'd4, 5'b00000}; // H ....
            6'd8:  entry = {3'd2, 5'b00000}; // I ..
            6'd9:  entry = {3'd4, 5'b01110}; // J .---
            6'd10: entry = {3'd3, 5'b10100}; // K -.-
            6'd11: entry = {3'd4, 5'b01000}; // L .-..
            6'd12: entry = {3'd2, 5'b11000}; // M --
            6'd13: entry = {3'd2, 5'b10000}; // N -.
            6'd14: entry = {3'd3, 5'b11100}; // O ---
            6'd15: entry = {3'd4, 5'b01100}; // P .--.
            6'd16: entry = {3'd4, 5'b11010}; // Q --.-
            6'd17: entry = {3'd3, 5'b01000}; // R .-.
            6'd18: entry = {3'd3, 5'b00000}; // S ...
            6'd19: entry = {3'd1, 5'b10000}; // T -
            6'd20: entry = {3'd3, 5'b00100}; // U ..-
            6'd21: entry = {3'd4, 5'b00010}; // V ...-
            6'd22: entry = {3'd3, 5'b01100}; // W .--
            6'd23: entry = {3'd4, 5'b10010}; // X -..-
            6'd24: entry = {3'd4, 5'b10110}; // Y -.--
            6'd25: entry = {3'd4, 5'b11000}; // Z --..
            6'd26: entry = {3'd5, 5'b11111}; // 0 -----
            6'd27: entry = {3'd5, 5'b01111}; // 1 .----
            6'd28: entry = {3'd5, 5'b00111}; // 2 ..---
            6'd29: entry = {3'd5, 5'b00011}; // 3 ...--
            6'd30: entry = {3'd5, 5'b00001}; // 4 ....-
            6'd31: entry = {3'd5, 5'b00000}; // 5 .....
            6'd32: entry = {3'd5, 5'b10000}; // 6 -....
            6'd33: entry = {3'd5, 5'b11000}; // 7 --...
            6'd34: entry = {3'd5, 5'b11100}; // 8 ---..
            6'd35: entry = {3'd5, 5'b11110}; // 9 ----.
            default: entry = 8'h00;
        endcase
    end

    // Codes above the last digit carry no pattern
    always_comb begin
        valid   = ({26'd0, char_code} <= CODE_MAX);
        length  = entry[7:5];
        pattern = entry[4:0];
    end

endmodule

// File: rtl/morse_tx_param.sv
// Parametrised Morse transmitter: start/busy/done handshake, abort, repeat and error pulse.
// MAX_LEN must be at least 5 so every ROM pattern fits; all unit counts must be >= 1.
module morse_tx_param
    import morse_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 25000000,
    parameter int unsigned MAX_LEN        = MORSE_MAX_LEN,
    parameter int unsigned DASH_UNITS     = 3,
    parameter int unsigned GAP_UNITS      = 1,
    parameter int unsigned CHAR_GAP_UNITS = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] char_code,
    input  logic       repeat_en,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TW  = $clog2(TICKS_PER_UNIT);
    localparam int unsigned UW  = $clog2(max3(DASH_UNITS, GAP_UNITS, CHAR_GAP_UNITS) + 1);
    localparam int unsigned CW  = $clog2(MAX_LEN + 1);
    localparam int unsigned PAD = (MAX_LEN > ROM_PAT_W) ? (MAX_LEN - ROM_PAT_W) : 0;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
    localparam logic [UW-1:0] DASH_LAST = UW'(DASH_UNITS - 1);
    localparam logic [UW-1:0] GAP_LAST  = UW'(GAP_UNITS - 1);
    localparam logic [UW-1:0] CGAP_LAST = UW'(CHAR_GAP_UNITS - 1);

    morse_state_e     state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [UW-1:0]    unit_q, unit_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [MAX_LEN-1:0] lat_pat_q, lat_pat_d;
    logic [CW-1:0]    lat_len_q, lat_len_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             rom_valid;
    logic [2:0]       rom_len;
    logic [4:0]       rom_pat;
    logic [MAX_LEN-1:0] rom_pat_ext;
    logic [UW-1:0]    unit_last;
    logic             tick_end;
    logic             phase_end;

    morse_rom u_rom (
        .char_code (char_code),
        .valid     (rom_valid),
        .length    (rom_len),
        .pattern   (rom_pat)
    );

    // Left-align the ROM pattern in the shift register so the MSB is always the current symbol
    always_comb begin
        rom_pat_ext = MAX_LEN'(rom_pat) << PAD;
    end

    // Terminal unit count of the current phase
    always_comb begin
        unit_last = '0;
        unique case (state_q)
            StMark:    unit_last = shift_q[MAX_LEN-1] ? DASH_LAST : '0;
            StSpace:   unit_last = GAP_LAST;
            StCharGap: unit_last = CGAP_LAST;
            default:   unit_last = '0;
        endcase
        tick_end  = (tick_q == TICK_LAST);
        phase_end = tick_end && (unit_q == unit_last);
    end

    // Next-state, counters and pattern handling
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        unit_d    = unit_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        lat_pat_d = lat_pat_q;
        lat_len_d = lat_len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (state_q == StIdle) begin
            tick_d = '0;
            unit_d = '0;
            // abort outranks start even though it does nothing else here
            if (start && !abort) begin
                if (rom_valid) begin
                    lat_pat_d = rom_pat_ext;
                    lat_len_d = CW'(rom_len);
                    shift_d   = rom_pat_ext;
                    rem_d     = CW'(rom_len);
                    state_d   = StMark;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (abort) begin
            state_d = StIdle;
            tick_d  = '0;
            unit_d  = '0;
        end else if (!tick_end) begin
            tick_d = tick_q + TW'(1);
        end else if (!phase_end) begin
            tick_d = '0;
            unit_d = unit_q + UW'(1);
        end else begin
            // Phase complete: counters restart for the next state
            tick_d = '0;
            unit_d = '0;
            unique case (state_q)
                StMark: begin
                    shift_d = shift_q << 1;
                    rem_d   = rem_q - CW'(1);
                    if (rem_q > CW'(1)) begin
                        state_d = StSpace;
                    end else if (repeat_en) begin
                        state_d = StCharGap;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                StSpace: begin
                    state_d = StMark;
                end
                StCharGap: begin
                    // Replay the latched character; char_code is not looked at again
                    shift_d = lat_pat_q;
                    rem_d   = lat_len_q;
                    state_d = StMark;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            unit_q    <= '0;
            shift_q   <= '0;
            rem_q     <= '0;
            lat_pat_q <= '0;
            lat_len_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            unit_q    <= unit_d;
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            lat_pat_q <= lat_pat_d;
            lat_len_q <= lat_len_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Outputs decoded from state so they clear with the asynchronous reset
    always_comb begin
        led  = (state_q == StMark);
        busy = (state_q != StIdle);
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_morse_tx_param.sv
// Self-checking bench for morse_tx_param with a per-cycle reference waveform built from Morse strings.
module tb_morse_tx_param;

    localparam int TPU   = 4;
    localparam int DASH  = 3;
    localparam int GAP   = 1;
    localparam int CGAP  = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] char_code;
    logic       repeat_en;
    logic       led;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    bit exp_q[$];

    string morse_tbl [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };

    morse_tx_param #(
        .TICKS_PER_UNIT (TPU)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .start     (start),
        .abort     (abort),
        .char_code (char_code),
        .repeat_en (repeat_en),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected LED level for every busy cycle, starting at cycle 1
    task automatic build_expect(input int code, input int reps);
        string s;
        int units;
        exp_q.delete();
        s = morse_tbl[code];
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < s.len(); i++) begin
                units = (s.getc(i) == "-") ? DASH : 1;
                for (int k = 0; k < units * TPU; k++) exp_q.push_back(1'b1);
                if (i < s.len() - 1)
                    for (int k = 0; k < GAP * TPU; k++) exp_q.push_back(1'b0);
            end
            if (r < reps - 1)
                for (int k = 0; k < CGAP * TPU; k++) exp_q.push_back(1'b0);
        end
    endtask

    // Transmit one character; reps>1 holds repeat_en until inside the final mark
    task automatic tx_char(input int code, input int reps, input int abort_cyc, input bit noise);
        int n;
        build_expect(code, reps);
        n = exp_q.size();
        char_code = 6'(code);
        repeat_en = (reps > 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= n; cyc++) begin
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                check("abort_led", led, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                abort = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check("abort_no_done", done, 1'b0);
                    check("abort_idle", busy, 1'b0);
                end
                return;
            end
            check("led", led, exp_q[cyc-1]);
            check("busy", busy, 1'b1);
            check("done_early", done, 1'b0);
            check("err_busy", err, 1'b0);
            if (abort_cyc != 0 && cyc == abort_cyc) abort = 1'b1;
            if (reps > 1 && cyc == n - 1) repeat_en = 1'b0;
            if (noise) begin
                start     = (cyc < n) ? 1'($urandom_range(0, 1)) : 1'b0;
                char_code = 6'($urandom_range(0, 63));
            end
            step();
        end
        start = 1'b0;
        check("done_pulse", done, 1'b1);
        check("busy_end", busy, 1'b0);
        check("led_end", led, 1'b0);
        step();
        check("done_once", done, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic tx_invalid(input int code);
        char_code = 6'(code);
        start = 1'b1;
        step();
        start = 1'b0;
        check("err_pulse", err, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_led", led, 1'b0);
        check("err_done", done, 1'b0);
        step();
        check("err_once", err, 1'b0);
        check("err_idle", busy, 1'b0);
    endtask

    initial begin
        int code;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        char_code = 6'd0;
        repeat_en = 1'b0;
        #3;
        check("rst_led", led, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 1'b0);

        // Directed characters: A, E, digit 0
        tx_char(0, 1, 0, 1'b0);
        tx_char(4, 1, 0, 1'b0);
        tx_char(26, 1, 0, 1'b0);

        // Invalid code
        tx_invalid(40);

        // Abort inside the first dash of B, then B again
        tx_char(1, 1, 10, 1'b0);
        tx_char(1, 1, 0, 1'b0);

        // Repeat mode with E, with start/char_code noise while busy
        tx_char(4, 3, 0, 1'b1);

        // Reset in the middle of the first dash of G
        char_code = 6'd6;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("g_led_pre", led, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_led", led, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_err", err, 1'b0);
        step();
        rst = 1'b0;
        step();
        check("arst_idle", busy, 1'b0);
        check("arst_no_done", done, 1'b0);
        tx_char(6, 1, 0, 1'b0);

        // Randomised characters, repeat counts and invalid codes
        for (int i = 0; i < 12; i++) begin
            code = int'($urandom_range(0, 63));
            if (code > 35) tx_invalid(code);
            else tx_char(code, int'($urandom_range(1, 2)), 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
